// File: rtl/tcb_lib_register_response.sv
// TCB response-path register slice: request passes through combinationally,
// manager response is registered, so a read delay of DLY becomes DLY+1 on sub.
module tcb_lib_register_response #(
    parameter  int unsigned AW  = 32,
    parameter  int unsigned DW  = 32,
    parameter  int unsigned DLY = 1,
    localparam int unsigned BEW = DW/8,
    localparam int unsigned PW  = $clog2(DLY+2)
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sub_vld,
    input  logic           sub_wen,
    input  logic [AW-1:0]  sub_adr,
    input  logic [BEW-1:0] sub_ben,
    input  logic [DW-1:0]  sub_wdt,
    output logic           sub_rdy,
    output logic [DW-1:0]  sub_rdt,
    output logic           sub_err,
    output logic           sub_rsv,
    output logic           man_vld,
    output logic           man_wen,
    output logic [AW-1:0]  man_adr,
    output logic [BEW-1:0] man_ben,
    output logic [DW-1:0]  man_wdt,
    input  logic           man_rdy,
    input  logic [DW-1:0]  man_rdt,
    input  logic           man_err,
    output logic [PW-1:0]  pend,
    output logic           idle
);

    logic           trn;
    logic           cap;
    logic           cwen;
    logic [DLY:0]   trk;

    assign man_vld = sub_vld;
    assign man_wen = sub_wen;
    assign man_adr = sub_adr;
    assign man_ben = sub_ben;
    assign man_wdt = sub_wdt;
    assign sub_rdy = man_rdy;

    assign trn = sub_vld & sub_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk <= '0;
        end else begin
            trk[0] <= trn;
            for (int unsigned i = 1; i <= DLY; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    // The last tracking stage is cap delayed by one edge, i.e. the response strobe.
    assign sub_rsv = trk[DLY];

    generate
        if (DLY == 0) begin : g_cap_direct
            assign cap  = trn;
            assign cwen = sub_wen;
        end else begin : g_cap_line
            logic [DLY-1:0] wtk;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wtk <= '0;
                end else begin
                    wtk[0] <= sub_wen;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        wtk[i] <= wtk[i-1];
                    end
                end
            end

            assign cap  = trk[DLY-1];
            assign cwen = wtk[DLY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_rdt <= '0;
            sub_err <= 1'b0;
        end else if (cap) begin
            sub_err <= man_err;
            if (!cwen) begin
                sub_rdt <= man_rdt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (trn && !cap) begin
            pend <= pend + PW'(1);
        end else if (!trn && cap) begin
            pend <= pend - PW'(1);
        end
    end

    assign idle = (pend == '0);

    generate
        if (DLY > 15) begin : g_bad_dly
            $error("tcb_lib_register_response: DLY must be in 0..15");
        end
    endgenerate

    a_pend_max: assert property (@(posedge clk) disable iff (!rst_n)
        int'(pend) <= int'(DLY) + 1);

    a_rsv_dec: assert property (@(posedge clk) disable iff (!rst_n)
        sub_rsv |-> (int'(pend) + 1 == int'($past(pend)) + int'($past(trn))));

endmodule

// File: tb/tb_tcb_lib_register_response.sv
// Bench for tcb_lib_register_response: instances with DLY=0,1,2 share the request
// inputs; each has its own manager response inputs.
module tb_tcb_lib_register_response;

    localparam int NI = 3;
    localparam int NC = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sub_vld, sub_wen, man_rdy;
    logic [31:0] sub_adr, sub_wdt;
    logic [3:0]  sub_ben;
    logic [31:0] man_rdt [NI];
    logic        man_err [NI];

    logic        sub_rdy [NI], sub_err [NI], sub_rsv [NI], idle [NI];
    logic        man_vld [NI], man_wen [NI];
    logic [31:0] sub_rdt [NI], man_adr [NI], man_wdt [NI];
    logic [3:0]  man_ben [NI];
    int          pend_v  [NI];

    int total = 0;
    int bad   = 0;

    bit          h_trn [NC];
    bit          h_wen [NC];
    logic [31:0] h_rdt [NI][NC];
    bit          h_err [NI][NC];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            logic [$clog2(g+2)-1:0] pend_w;
            tcb_lib_register_response #(.AW(32), .DW(32), .DLY(g)) u_dut (
                .clk(clk), .rst_n(rst_n),
                .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr),
                .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdy(sub_rdy[g]),
                .sub_rdt(sub_rdt[g]), .sub_err(sub_err[g]), .sub_rsv(sub_rsv[g]),
                .man_vld(man_vld[g]), .man_wen(man_wen[g]), .man_adr(man_adr[g]),
                .man_ben(man_ben[g]), .man_wdt(man_wdt[g]), .man_rdy(man_rdy),
                .man_rdt(man_rdt[g]), .man_err(man_err[g]),
                .pend(pend_w), .idle(idle[g])
            );
            assign pend_v[g] = int'(pend_w);
        end
    endgenerate

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        sub_vld = 1'b0;
        sub_wen = 1'b0;
        man_rdy = 1'b1;
        for (int k = 0; k < NI; k++) begin
            man_rdt[k] = $urandom;
            man_err[k] = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            quiet();
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        quiet();
        sub_vld = 1'b1;
        sub_wen = 1'b1;
        sub_adr = 32'h1234_5678;
        sub_ben = 4'hA;
        sub_wdt = 32'h0BAD_F00D;
        man_rdy = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++; if (sub_rsv[k] !== 1'b0) begin bad++; $display("FAIL reset_rsv[%0d] got=%b exp=0", k, sub_rsv[k]); end
            total++; if (sub_rdt[k] !== 32'h0) begin bad++; $display("FAIL reset_rdt[%0d] got=%h exp=0", k, sub_rdt[k]); end
            total++; if (sub_err[k] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", k, sub_err[k]); end
            total++; if (pend_v[k] != 0) begin bad++; $display("FAIL reset_pend[%0d] got=%0d exp=0", k, pend_v[k]); end
            total++; if (idle[k] !== 1'b1) begin bad++; $display("FAIL reset_idle[%0d] got=%b exp=1", k, idle[k]); end
            total++; if (man_adr[k] !== 32'h1234_5678) begin bad++; $display("FAIL reset_adr[%0d] got=%h exp=12345678", k, man_adr[k]); end
            total++; if (man_ben[k] !== 4'hA || man_wen[k] !== 1'b1 || man_vld[k] !== 1'b1) begin
                bad++; $display("FAIL reset_req[%0d] got=%h/%b/%b exp=a/1/1", k, man_ben[k], man_wen[k], man_vld[k]); end
            total++; if (sub_rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_rdy0[%0d] got=%b exp=0", k, sub_rdy[k]); end
        end
        man_rdy = 1'b1;
        #1;
        total++; if (sub_rdy[0] !== 1'b1) begin bad++; $display("FAIL reset_rdy1 got=%b exp=1", sub_rdy[0]); end
        next_cycle();
        rst_n = 1'b1;
        drain(2);
    endtask

    task automatic test_read_dly1();
        quiet();
        sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h10;
        next_cycle();
        quiet();
        man_rdt[1] = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b0) begin bad++; $display("FAIL dly1_rsv_t1 got=%b exp=0", sub_rsv[1]); end
        total++; if (pend_v[1] != 1) begin bad++; $display("FAIL dly1_pend_t1 got=%0d exp=1", pend_v[1]); end
        next_cycle();
        quiet();
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b1) begin bad++; $display("FAIL dly1_rsv_t2 got=%b exp=1", sub_rsv[1]); end
        total++; if (sub_rdt[1] !== 32'hCAFE_F00D) begin bad++; $display("FAIL dly1_rdt_t2 got=%h exp=cafef00d", sub_rdt[1]); end
        total++; if (pend_v[1] != 0 || idle[1] !== 1'b1) begin bad++; $display("FAIL dly1_pend_t2 got=%0d/%b exp=0/1", pend_v[1], idle[1]); end
        next_cycle();
        quiet();
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b0) begin bad++; $display("FAIL dly1_rsv_t3 got=%b exp=0", sub_rsv[1]); end
        total++; if (sub_rdt[1] !== 32'hCAFE_F00D) begin bad++; $display("FAIL dly1_rdt_hold got=%h exp=cafef00d", sub_rdt[1]); end
        next_cycle();
        drain(4);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int maxp   = 0;
        for (int c = 0; c < 6; c++) begin
            quiet();
            if (c < 4) begin
                sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'(c * 4);
                man_rdt[0] = 32'(c + 1);
            end
            @(negedge clk);
            if (sub_rsv[0] === 1'b1) pulses++;
            if (pend_v[0] > maxp) maxp = pend_v[0];
            total++; if (sub_rsv[0] !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL b2b_rsv c=%0d got=%b exp=%b", c, sub_rsv[0], (c >= 1 && c <= 4)); end
            if (c >= 1) begin
                total++; if (sub_rdt[0] !== 32'((c <= 4) ? c : 4)) begin
                    bad++; $display("FAIL b2b_rdt c=%0d got=%h exp=%h", c, sub_rdt[0], ((c <= 4) ? c : 4)); end
            end
            next_cycle();
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
        total++; if (maxp > 1) begin bad++; $display("FAIL b2b_pend_max got=%0d exp<=1", maxp); end
        drain(4);
    endtask

    task automatic test_write_hold();
        quiet();
        sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h20;
        next_cycle();
        quiet();
        sub_vld = 1'b1; sub_wen = 1'b1; sub_adr = 32'h24; sub_wdt = 32'h5555_5555;
        man_rdt[1] = 32'hAAAA_0000;
        next_cycle();
        quiet();
        man_rdt[1] = 32'h1234_5678; man_err[1] = 1'b1;
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b1 || sub_rdt[1] !== 32'hAAAA_0000 || sub_err[1] !== 1'b0) begin
            bad++; $display("FAIL wr_read_rsp got=%b/%h/%b exp=1/aaaa0000/0", sub_rsv[1], sub_rdt[1], sub_err[1]); end
        next_cycle();
        quiet();
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b1) begin bad++; $display("FAIL wr_rsv got=%b exp=1", sub_rsv[1]); end
        total++; if (sub_rdt[1] !== 32'hAAAA_0000) begin bad++; $display("FAIL wr_rdt_hold got=%h exp=aaaa0000", sub_rdt[1]); end
        total++; if (sub_err[1] !== 1'b1) begin bad++; $display("FAIL wr_err got=%b exp=1", sub_err[1]); end
        next_cycle();
        quiet();
        @(negedge clk);
        total++; if (sub_rsv[1] !== 1'b0 || sub_err[1] !== 1'b1) begin
            bad++; $display("FAIL wr_after got=%b/%b exp=0/1", sub_rsv[1], sub_err[1]); end
        next_cycle();
        drain(4);
    endtask

    task automatic test_rdy_toggle();
        bit trn [8];
        int pulses = 0;
        for (int c = 0; c < 8; c++) begin
            quiet();
            sub_vld = (c < 3);
            man_rdy = (c != 1);
            trn[c]  = sub_vld && man_rdy;
            @(negedge clk);
            begin
                bit e_rsv;
                int e_pend;
                e_rsv  = (c >= 3) && trn[c-3];
                e_pend = 0;
                for (int t = c - 2; t <= c - 1; t++) if (t >= 0 && trn[t]) e_pend++;
                if (sub_rsv[2] === 1'b1) pulses++;
                total++; if (sub_rsv[2] !== e_rsv) begin bad++; $display("FAIL rdy_rsv c=%0d got=%b exp=%b", c, sub_rsv[2], e_rsv); end
                total++; if (pend_v[2] != e_pend) begin bad++; $display("FAIL rdy_pend c=%0d got=%0d exp=%0d", c, pend_v[2], e_pend); end
            end
            next_cycle();
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL rdy_pulses got=%0d exp=2", pulses); end
        drain(4);
    endtask

    task automatic test_reset_midflight();
        quiet();
        sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h30;
        next_cycle();
        quiet();
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                total++; if (sub_rsv[k] !== 1'b0 || pend_v[k] != 0 || idle[k] !== 1'b1 || sub_rdt[k] !== 32'h0) begin
                    bad++; $display("FAIL midrst c=%0d k=%0d got=%b/%0d/%b/%h exp=0/0/1/0", c, k, sub_rsv[k], pend_v[k], idle[k], sub_rdt[k]); end
            end
            next_cycle();
            rst_n = 1'b1;
            quiet();
        end
    endtask

    task automatic test_random();
        logic [31:0] e_rdt [NI];
        bit          e_err [NI];
        int          last_rst = 0;
        for (int n = 0; n < NC; n++) begin
            rst_n   = (n == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
            sub_vld = ($urandom_range(0, 9) < 7);
            sub_wen = 1'($urandom_range(0, 1));
            sub_adr = $urandom;
            sub_ben = 4'($urandom);
            sub_wdt = $urandom;
            man_rdy = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < NI; k++) begin
                man_rdt[k]  = $urandom;
                man_err[k]  = 1'($urandom_range(0, 1));
                h_rdt[k][n] = man_rdt[k];
                h_err[k][n] = man_err[k];
            end
            h_trn[n] = rst_n && sub_vld && man_rdy;
            h_wen[n] = sub_wen;
            if (!rst_n) last_rst = n;
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                bit e_rsv;
                int e_pend;
                e_rsv  = 1'b0;
                e_pend = 0;
                if (!rst_n) begin
                    e_rdt[k] = '0;
                    e_err[k] = 1'b0;
                end else begin
                    // transfer in cycle T answers in cycle T+DLY+1 with manager data from T+DLY
                    int t;
                    t = n - k - 1;
                    e_rsv = (t > last_rst) && h_trn[t];
                    if (e_rsv) begin
                        e_err[k] = h_err[k][n-1];
                        if (!h_wen[t]) e_rdt[k] = h_rdt[k][n-1];
                    end
                    for (int u = n - k; u <= n - 1; u++) if (u > last_rst && h_trn[u]) e_pend++;
                end
                total++; if (man_adr[k] !== sub_adr || man_wdt[k] !== sub_wdt || man_vld[k] !== sub_vld || sub_rdy[k] !== man_rdy) begin
                    bad++; $display("FAIL rnd_pass n=%0d k=%0d got=%h/%b exp=%h/%b", n, k, man_adr[k], sub_rdy[k], sub_adr, man_rdy); end
                total++; if (sub_rsv[k] !== e_rsv) begin bad++; $display("FAIL rnd_rsv n=%0d k=%0d got=%b exp=%b", n, k, sub_rsv[k], e_rsv); end
                total++; if (sub_rdt[k] !== e_rdt[k]) begin bad++; $display("FAIL rnd_rdt n=%0d k=%0d got=%h exp=%h", n, k, sub_rdt[k], e_rdt[k]); end
                total++; if (sub_err[k] !== e_err[k]) begin bad++; $display("FAIL rnd_err n=%0d k=%0d got=%b exp=%b", n, k, sub_err[k], e_err[k]); end
                total++; if (pend_v[k] != e_pend || idle[k] !== (e_pend == 0)) begin
                    bad++; $display("FAIL rnd_pend n=%0d k=%0d got=%0d/%b exp=%0d/%b", n, k, pend_v[k], idle[k], e_pend, (e_pend == 0)); end
            end
            next_cycle();
        end
        rst_n = 1'b1;
        drain(4);
    endtask

    initial begin
        rst_n   = 1'b0;
        sub_adr = '0;
        sub_ben = '0;
        sub_wdt = '0;
        quiet();
        test_reset();
        test_read_dly1();
        test_back_to_back();
        test_write_hold();
        test_rdy_toggle();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
